// File: rtl/conv1x1_layer_sequencer_if.sv
// Control, configuration and engine-handshake bundle of the 1x1 conv layer sequencer.
// The master side drives the layer request and the engine's done; the slave is the sequencer.
interface conv1x1_layer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              layer_start;
    logic              layer_abort;
    logic [15:0]       cfg_num_pixel;
    logic [7:0]        cfg_in_ch;
    logic [7:0]        cfg_num_filter;
    logic [ADDR_W-1:0] cfg_ifm_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic [ADDR_W-1:0] cfg_ofm_base;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_ifm_addr;
    logic [ADDR_W-1:0] eng_wgt_addr;
    logic [ADDR_W-1:0] eng_ofm_addr;
    logic              eng_done;
    logic              layer_busy;
    logic              layer_done;
    logic              cfg_err;
    logic [15:0]       pass_count;

    modport master (
        output layer_start, layer_abort, cfg_num_pixel, cfg_in_ch, cfg_num_filter,
               cfg_ifm_base, cfg_wgt_base, cfg_ofm_base, eng_done,
        input  eng_start, eng_ifm_addr, eng_wgt_addr, eng_ofm_addr,
               layer_busy, layer_done, cfg_err, pass_count
    );

    modport slave (
        input  layer_start, layer_abort, cfg_num_pixel, cfg_in_ch, cfg_num_filter,
               cfg_ifm_base, cfg_wgt_base, cfg_ofm_base, eng_done,
        output eng_start, eng_ifm_addr, eng_wgt_addr, eng_ofm_addr,
               layer_busy, layer_done, cfg_err, pass_count
    );
endinterface

// File: rtl/conv1x1_layer_sequencer.sv
// Splits a 1x1 conv layer into PE_PIX x PE_FLT passes (filter groups outer) and hands each to the engine.
// eng_start fires 2 cycles after an accepted layer_start and 2 cycles after each NEXT; the engine throttles via eng_done.
module conv1x1_layer_sequencer #(
    parameter int ADDR_W = 32,
    parameter int PE_PIX = 4,
    parameter int PE_FLT = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    conv1x1_layer_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic [15:0]       r_num_pixel;
    logic [7:0]        r_num_filter;
    logic [ADDR_W-1:0] r_ifm_base;
    logic [ADDR_W-1:0] r_ofm_base;
    logic [ADDR_W-1:0] r_ifm_stride;
    logic [ADDR_W-1:0] r_ofm_stride;
    logic [ADDR_W-1:0] r_wgt_stride;
    logic [15:0]       r_pix;
    logic [7:0]        r_flt;
    logic [15:0]       r_pass_count;
    logic [ADDR_W-1:0] r_ifm_addr;
    logic [ADDR_W-1:0] r_wgt_addr;
    logic [ADDR_W-1:0] r_ofm_addr;
    logic              r_eng_start;
    logic              r_layer_done;
    logic              r_cfg_err;

    logic              w_accept;
    logic              w_cfg_ok;
    logic              w_last_pix;
    logic              w_last_flt;
    logic              w_advance;
    logic [7:0]        w_flt_nx;

    // An abort in IDLE still blocks a simultaneous start.
    assign w_accept = (r_state == IDLE) && bus.layer_start && !bus.layer_abort;

    assign w_cfg_ok = (bus.cfg_num_pixel != 16'd0)
                   && ((bus.cfg_num_pixel % 16'(PE_PIX)) == 16'd0)
                   && (bus.cfg_in_ch != 8'd0)
                   && (bus.cfg_in_ch[1:0] == 2'b00)
                   && (bus.cfg_num_filter != 8'd0)
                   && ((bus.cfg_num_filter % 8'(PE_FLT)) == 8'd0);

    assign w_last_pix = ({1'b0, r_pix} + 17'(PE_PIX)) >= {1'b0, r_num_pixel};
    assign w_last_flt = ({1'b0, r_flt} + 9'(PE_FLT)) >= {1'b0, r_num_filter};
    assign w_flt_nx   = r_flt + 8'(PE_FLT);
    assign w_advance  = (r_state == NEXT) && !bus.layer_abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_cfg_ok) w_state_nx = ISSUE;
            ISSUE:   w_state_nx = WAIT;
            WAIT:    if (bus.eng_done) w_state_nx = NEXT;
            NEXT:    w_state_nx = (w_last_pix && w_last_flt) ? DONE : ISSUE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (r_state != IDLE && bus.layer_abort) begin
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eng_start  <= 1'b0;
            r_layer_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_eng_start  <= (r_state == ISSUE) && !bus.layer_abort;
            r_layer_done <= (r_state == NEXT) && (w_state_nx == DONE);
            r_cfg_err    <= w_accept && !w_cfg_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_pixel  <= '0;
            r_num_filter <= '0;
            r_ifm_base   <= '0;
            r_ofm_base   <= '0;
            r_ifm_stride <= '0;
            r_ofm_stride <= '0;
            r_wgt_stride <= '0;
            r_pix        <= '0;
            r_flt        <= '0;
            r_pass_count <= '0;
            r_ifm_addr   <= '0;
            r_wgt_addr   <= '0;
            r_ofm_addr   <= '0;
        end else if (w_accept) begin
            r_num_pixel  <= bus.cfg_num_pixel;
            r_num_filter <= bus.cfg_num_filter;
            r_ifm_base   <= bus.cfg_ifm_base;
            r_ofm_base   <= bus.cfg_ofm_base;
            // Strides are fixed for the whole layer, so the pass loop only ever adds.
            r_ifm_stride <= ADDR_W'(PE_PIX) * ADDR_W'(bus.cfg_in_ch);
            r_ofm_stride <= ADDR_W'(PE_PIX) * ADDR_W'(bus.cfg_num_filter);
            r_wgt_stride <= ADDR_W'(PE_FLT) * ADDR_W'(bus.cfg_in_ch);
            if (w_cfg_ok) begin
                r_pix        <= '0;
                r_flt        <= '0;
                r_pass_count <= '0;
                r_ifm_addr   <= bus.cfg_ifm_base;
                r_wgt_addr   <= bus.cfg_wgt_base;
                r_ofm_addr   <= bus.cfg_ofm_base;
            end
        end else if (w_advance) begin
            r_pass_count <= r_pass_count + 16'd1;
            if (!w_last_pix) begin
                r_pix      <= r_pix + 16'(PE_PIX);
                r_ifm_addr <= r_ifm_addr + r_ifm_stride;
                r_ofm_addr <= r_ofm_addr + r_ofm_stride;
            end else if (!w_last_flt) begin
                r_pix      <= '0;
                r_flt      <= w_flt_nx;
                r_ifm_addr <= r_ifm_base;
                r_wgt_addr <= r_wgt_addr + r_wgt_stride;
                r_ofm_addr <= r_ofm_base + ADDR_W'(w_flt_nx);
            end
        end
    end

    assign bus.eng_start    = r_eng_start;
    assign bus.eng_ifm_addr = r_ifm_addr;
    assign bus.eng_wgt_addr = r_wgt_addr;
    assign bus.eng_ofm_addr = r_ofm_addr;
    assign bus.layer_busy   = (r_state != IDLE);
    assign bus.layer_done   = r_layer_done;
    assign bus.cfg_err      = r_cfg_err;
    assign bus.pass_count   = r_pass_count;
endmodule

// File: tb/tb_conv1x1_layer_sequencer.sv
// Directed bench for conv1x1_layer_sequencer: expected pass addresses are queued when a layer
// is started and checked against every eng_start the sequencer produces.
module tb_conv1x1_layer_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    conv1x1_layer_sequencer_if #(.ADDR_W(32)) bus ();

    conv1x1_layer_sequencer #(.ADDR_W(32), .PE_PIX(4), .PE_FLT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ifm;
        logic [31:0] wgt;
        logic [31:0] ofm;
    } pass_t;

    pass_t sb[$];
    int n_err    = 0;
    int n_checks = 0;
    int n_start  = 0;
    int n_done   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every pass start pops one expected address triple.
    always @(negedge clk) begin
        if (bus.eng_start === 1'b1) begin
            pass_t e;
            n_start++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ifm_addr", bus.eng_ifm_addr, e.ifm);
                chk("wgt_addr", bus.eng_wgt_addr, e.wgt);
                chk("ofm_addr", bus.eng_ofm_addr, e.ofm);
            end
        end
        if (bus.layer_done === 1'b1) n_done++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] np, input logic [7:0] ic, input logic [7:0] nf,
                           input logic [31:0] ifm, input logic [31:0] wgt, input logic [31:0] ofm);
        bus.cfg_num_pixel  = np;
        bus.cfg_in_ch      = ic;
        bus.cfg_num_filter = nf;
        bus.cfg_ifm_base   = ifm;
        bus.cfg_wgt_base   = wgt;
        bus.cfg_ofm_base   = ofm;
    endtask

    task automatic push(input logic [31:0] ifm, input logic [31:0] wgt, input logic [31:0] ofm);
        pass_t e;
        e.ifm = ifm;
        e.wgt = wgt;
        e.ofm = ofm;
        sb.push_back(e);
    endtask

    task automatic start_layer();
        bus.layer_start = 1'b1;
        tick();
        bus.layer_start = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (bus.eng_start !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk(tag, 32'(bus.eng_start), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (bus.layer_done !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk(tag, 32'(bus.layer_done), 32'd1);
    endtask

    // Engine model: done 5 cycles after start; optionally pokes stray inputs while waiting.
    task automatic engine_pass(input string tag, input bit poke);
        wait_start(tag);
        for (int i = 0; i < 5; i++) begin
            if (poke && i == 1) begin
                bus.layer_start  = 1'b1;
                bus.cfg_ifm_base = 32'hDEAD0000;
            end
            tick();
            bus.layer_start = 1'b0;
        end
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
    endtask

    initial begin
        int s0;
        int d0;
        bus.layer_start = 1'b0;
        bus.layer_abort = 1'b0;
        bus.eng_done    = 1'b0;
        set_cfg(16'd0, 8'd0, 8'd0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("rst_busy",   32'(bus.layer_busy), 32'd0);
        chk("rst_start",  32'(bus.eng_start), 32'd0);
        chk("rst_done",   32'(bus.layer_done), 32'd0);
        chk("rst_cfgerr", 32'(bus.cfg_err), 32'd0);
        chk("rst_pcount", 32'(bus.pass_count), 32'd0);
        chk("rst_ofm",    bus.eng_ofm_addr, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic 4-pass layer
        set_cfg(16'd8, 8'd8, 8'd8, 32'h1000, 32'h2000, 32'h3000);
        push(32'h1000, 32'h2000, 32'h3000);
        push(32'h1020, 32'h2000, 32'h3020);
        push(32'h1000, 32'h2020, 32'h3004);
        push(32'h1020, 32'h2020, 32'h3024);
        d0 = n_done;
        start_layer();
        chk("basic_busy", 32'(bus.layer_busy), 32'd1);
        for (int p = 0; p < 4; p++) engine_pass("basic_start", 1'b0);
        wait_done("basic_done");
        chk("basic_pcount", 32'(bus.pass_count), 32'd4);
        tick();
        chk("basic_idle", 32'(bus.layer_busy), 32'd0);
        chk("basic_ndone", 32'(n_done - d0), 32'd1);
        chk("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Minimal layer: cycle-exact latencies
        set_cfg(16'd4, 8'd4, 8'd4, 32'h100, 32'h200, 32'h300);
        push(32'h100, 32'h200, 32'h300);
        s0 = n_start;
        start_layer();
        chk("min_lat1", 32'(bus.eng_start), 32'd0);
        tick();
        chk("min_lat2", 32'(bus.eng_start), 32'd1);
        repeat (5) tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("min_done1", 32'(bus.layer_done), 32'd0);
        tick();
        chk("min_done2", 32'(bus.layer_done), 32'd1);
        tick();
        chk("min_done_pulse", 32'(bus.layer_done), 32'd0);
        chk("min_idle", 32'(bus.layer_busy), 32'd0);
        chk("min_nstart", 32'(n_start - s0), 32'd1);

        // Rejected configurations
        s0 = n_start;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       set_cfg(16'd8, 8'd6, 8'd4, 32'h0, 32'h0, 32'h0);
                1:       set_cfg(16'd0, 8'd4, 8'd4, 32'h0, 32'h0, 32'h0);
                default: set_cfg(16'd8, 8'd4, 8'd2, 32'h0, 32'h0, 32'h0);
            endcase
            start_layer();
            chk("cfgerr_pulse", 32'(bus.cfg_err), 32'd1);
            chk("cfgerr_busy", 32'(bus.layer_busy), 32'd0);
            tick();
            chk("cfgerr_clear", 32'(bus.cfg_err), 32'd0);
        end
        repeat (4) tick();
        chk("cfgerr_nstart", 32'(n_start - s0), 32'd0);

        // Abort in IDLE blocks a simultaneous start
        set_cfg(16'd4, 8'd4, 8'd4, 32'h0, 32'h0, 32'h0);
        bus.layer_abort = 1'b1;
        start_layer();
        bus.layer_abort = 1'b0;
        chk("idle_abort_busy", 32'(bus.layer_busy), 32'd0);

        // Abort in WAIT of pass 2 together with eng_done
        set_cfg(16'd8, 8'd8, 8'd8, 32'h1000, 32'h2000, 32'h3000);
        push(32'h1000, 32'h2000, 32'h3000);
        push(32'h1020, 32'h2000, 32'h3020);
        s0 = n_start;
        d0 = n_done;
        start_layer();
        engine_pass("abort_p1", 1'b0);
        wait_start("abort_p2");
        repeat (2) tick();
        bus.eng_done    = 1'b1;
        bus.layer_abort = 1'b1;
        tick();
        bus.eng_done    = 1'b0;
        bus.layer_abort = 1'b0;
        chk("abort_busy", 32'(bus.layer_busy), 32'd0);
        chk("abort_pcount", 32'(bus.pass_count), 32'd1);
        chk("abort_ofm_hold", bus.eng_ofm_addr, 32'h3020);
        // Stray done while idle
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        repeat (10) tick();
        chk("abort_nstart", 32'(n_start - s0), 32'd2);
        chk("abort_ndone", 32'(n_done - d0), 32'd0);
        chk("abort_still_idle", 32'(bus.layer_busy), 32'd0);

        // Restart with stray layer_start in WAIT and eng_done in ISSUE
        push(32'h1000, 32'h2000, 32'h3000);
        push(32'h1020, 32'h2000, 32'h3020);
        push(32'h1000, 32'h2020, 32'h3004);
        push(32'h1020, 32'h2020, 32'h3024);
        d0 = n_done;
        start_layer();
        chk("restart_pcount", 32'(bus.pass_count), 32'd0);
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        for (int p = 0; p < 4; p++) engine_pass("restart_start", 1'b1);
        wait_done("restart_done");
        chk("restart_pc4", 32'(bus.pass_count), 32'd4);
        tick();
        chk("restart_ndone", 32'(n_done - d0), 32'd1);

        // Address wrap, then asynchronous reset mid-layer
        set_cfg(16'd8, 8'd4, 8'd4, 32'h0, 32'h0, 32'hFFFFFFF0);
        push(32'h0, 32'h0, 32'hFFFFFFF0);
        push(32'h10, 32'h0, 32'h00000000);
        start_layer();
        engine_pass("wrap_p1", 1'b0);
        wait_start("wrap_p2");
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy",   32'(bus.layer_busy), 32'd0);
        chk("arst_start",  32'(bus.eng_start), 32'd0);
        chk("arst_pcount", 32'(bus.pass_count), 32'd0);
        chk("arst_ifm",    bus.eng_ifm_addr, 32'd0);
        chk("arst_ofm",    bus.eng_ofm_addr, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/conv1x1_layer_sequencer.md
Name: conv1x1_layer_sequencer

Overview:
Layer-level scheduler for the 1x1 convolution engine. It latches one layer's configuration and splits the layer into passes. Each pass covers PE_PIX pixels x PE_FLT filters x the full input-channel depth. For each pass it issues a start/done handshake to the engine, with IFM, weight and OFM base addresses. Loop order is weight-stationary: filter groups outer, pixel groups inner.

Parameters:
ADDR_W, 32, width of all address ports
PE_PIX, 4, pixels computed per pass
PE_FLT, 4, filters computed per pass

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
layer_start  in  1  start request; sampled only in IDLE
layer_abort  in  1  synchronous abort; returns to IDLE
cfg_num_pixel  in  16  pixels in layer (H*W)
cfg_in_ch  in  8  input channels
cfg_num_filter  in  8  output filters
cfg_ifm_base  in  ADDR_W  IFM base byte address
cfg_wgt_base  in  ADDR_W  weight base byte address
cfg_ofm_base  in  ADDR_W  OFM base byte address
eng_start  out  1  one-cycle pass start pulse
eng_ifm_addr  out  ADDR_W  IFM address of current pass
eng_wgt_addr  out  ADDR_W  weight address of current pass
eng_ofm_addr  out  ADDR_W  OFM address of current pass
eng_done  in  1  pass complete; sampled only in WAIT
layer_busy  out  1  high in any state other than IDLE
layer_done  out  1  one-cycle pulse when the layer completes
cfg_err  out  1  one-cycle pulse when the config is rejected
pass_count  out  16  passes completed in the current layer

Behaviour:
- Reset and decided interface: reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, state IDLE, all internal counters 0.
- Data layout: one byte per element. IFM is pixel-major (pixel p at base + p*in_ch). Weights are filter-major (filter f at base + f*in_ch). OFM is pixel-major (base + p*num_filter + f).
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE, layer_start=1:
  - Latch all cfg_* inputs.
  - Config is valid when num_pixel is nonzero and a multiple of PE_PIX, in_ch is nonzero and a multiple of 4, and num_filter is nonzero and a multiple of PE_FLT.
  - Invalid config: cfg_err=1 for the next cycle; stay in IDLE; no pass issued.
  - Valid config: load eng_ifm_addr=ifm_base, eng_wgt_addr=wgt_base, eng_ofm_addr=ofm_base; clear pass_count and the pixel/filter counters; go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle, then go to WAIT. Addresses are valid in this cycle and held stable until NEXT.
- WAIT: stay until eng_done=1, then go to NEXT. eng_done in any other state is ignored.
- NEXT (one cycle): pass_count += 1.
  - More pixel groups remain in the current filter group:
    - pix += PE_PIX
    - eng_ifm_addr += PE_PIX*in_ch
    - eng_ofm_addr += PE_PIX*num_filter
    - go to ISSUE
  - Last pixel group, more filter groups remain:
    - pix = 0, flt += PE_FLT
    - eng_ifm_addr = ifm_base
    - eng_wgt_addr += PE_FLT*in_ch
    - eng_ofm_addr = ofm_base + flt_new
    - go to ISSUE
  - Last pixel group and last filter group: go to DONE.
- DONE: layer_done=1 for one cycle, then go to IDLE. pass_count holds its value until the next accepted layer_start.
- Address arithmetic: incremental adds only, no multipliers in the loop. Stride products are precomputed once at start, as shift or multiply of a constant PE_* parameter, and stored ADDR_W wide. Address sums wrap modulo 2^ADDR_W.
- Total passes = (num_pixel/PE_PIX) * (num_filter/PE_FLT). The start-to-first-eng_start latency is 2 cycles. NEXT-to-ISSUE overhead is 2 cycles per pass.
- layer_start while busy: ignored; the latched config does not change.
- layer_abort: in any non-IDLE state it forces IDLE at the next edge, with no layer_done and no eng_start. Addresses and pass_count hold their values. Abort has priority over eng_done arriving in the same cycle. Abort in IDLE has no effect, and layer_start is not accepted in that cycle.
- Reset mid-layer: immediate return to reset values; the engine is expected to be reset by the same reset_n.

Test Plan:
- Basic 4-pass layer: num_pixel=8, in_ch=8, num_filter=8, bases 0x1000/0x2000/0x3000, engine returns eng_done 5 cycles after each start. Required (ifm, wgt, ofm) per pass, in order:
  - 1: (0x1000, 0x2000, 0x3000)
  - 2: (0x1020, 0x2000, 0x3020)
  - 3: (0x1000, 0x2020, 0x3004)
  - 4: (0x1020, 0x2020, 0x3024)
  - then layer_done once and pass_count=4.
- Minimal layer: num_pixel=4, in_ch=4, num_filter=4 -> exactly one eng_start, 2 cycles after layer_start; layer_done 2 cycles after eng_done.
- Config error: in_ch=6 (also num_pixel=0, num_filter=2) -> cfg_err pulse, layer_busy stays 0, no eng_start.
- Abort and stray done: layer_abort in WAIT of pass 2, with eng_done asserted in the same cycle -> IDLE next cycle, no further eng_start, no layer_done, pass_count=1. A following start then runs normally from pass_count=0.
- Ignored inputs: layer_start pulses during WAIT and eng_done pulses during ISSUE/IDLE -> no effect on sequence or addresses.
- Address wrap: ofm_base=0xFFFFFFF0, num_pixel=8, num_filter=4 -> pass 2 eng_ofm_addr=0x00000000. Then reset_n low mid-layer -> all outputs 0 immediately.
